// File: rtl/mb8_pkg.sv
// Shared widths, FSM states and request bundle for the 8-bit memory bus master adapter.
package mb8_pkg;

  localparam int DSZ = 8;
  localparam int ASZ = 17;
  localparam int CSZ = 32;
  localparam int NB  = CSZ / DSZ;
  localparam int KW  = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RTAIL
  } mb8_st_t;

  typedef struct packed {
    logic           we;
    logic           byte_op;
    logic [ASZ-1:0] addr;
    logic [CSZ-1:0] wdata;
  } mb8_req_t;

  // Little-endian byte lane i of a cell.
  function automatic logic [DSZ-1:0] mb8_lane(input logic [CSZ-1:0] w, input logic [KW-1:0] i);
    return w[i*DSZ +: DSZ];
  endfunction

endpackage

// File: rtl/mb8_addr_seq.sv
// Beat counter and wrapping byte-address generator for one cell/byte access.
module mb8_addr_seq
  import mb8_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           adv,
  input  logic [ASZ-1:0] base,
  input  logic [KW:0]    len,
  output logic [ASZ-1:0] ai,
  output logic [KW-1:0]  k,
  output logic           last
);

  logic [KW:0] len_reg;

  // The address register doubles as the bus address, so it simply holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai      <= '0;
      k       <= '0;
      len_reg <= (KW+1)'(NB);
    end else if (load) begin
      ai      <= base;
      k       <= '0;
      len_reg <= len;
    end else if (adv) begin
      ai <= ai + ASZ'(1);
      k  <= k + KW'(1);
    end
  end

  assign last = ({1'b0, k} == (len_reg - (KW+1)'(1)));

endmodule

// File: rtl/mb8_cell_rw.sv
// Master-side adapter turning cell/byte load-store requests into sequential mb8_io byte beats.
module mb8_cell_rw
  import mb8_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic           req_byte,
  input  logic [ASZ-1:0] req_addr,
  input  logic [CSZ-1:0] req_wdata,
  output logic           rsp_valid,
  output logic [CSZ-1:0] rsp_data,
  output logic           mb_we,
  output logic [ASZ-1:0] mb_ai,
  output logic [DSZ-1:0] mb_vi,
  input  logic [DSZ-1:0] mb_vo
);

  mb8_st_t            state_reg;
  mb8_req_t           req;
  logic               byte_reg;
  logic [CSZ-1:0]     wdata_reg;
  logic [CSZ-DSZ-1:0] shift_reg;
  logic               load;
  logic               adv;
  logic               last;
  logic [KW-1:0]      k;
  logic [KW:0]        len;

  assign req = '{we: req_we, byte_op: req_byte, addr: req_addr, wdata: req_wdata};

  assign req_ready = (state_reg == IDLE);
  assign load      = req_valid & req_ready;
  assign adv       = ((state_reg == WR) || (state_reg == RD)) & ~last;
  assign len       = req.byte_op ? (KW+1)'(1) : (KW+1)'(NB);

  mb8_addr_seq u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .adv   (adv),
    .base  (req.addr),
    .len   (len),
    .ai    (mb_ai),
    .k     (k),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      byte_reg  <= 1'b0;
      wdata_reg <= '0;
      shift_reg <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      mb_we     <= 1'b0;
      mb_vi     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            byte_reg  <= req.byte_op;
            wdata_reg <= req.wdata;
            if (req.we) begin
              state_reg <= WR;
              mb_we     <= 1'b1;
              mb_vi     <= req.wdata[DSZ-1:0];
            end else begin
              state_reg <= RD;
            end
          end
        end
        WR: begin
          if (last) begin
            state_reg <= IDLE;
            mb_we     <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            mb_vi <= mb8_lane(wdata_reg, k + KW'(1));
          end
        end
        RD: begin
          // mb_vo lags the address by one cycle: during beat k it carries byte k-1.
          if (k != '0) begin
            shift_reg <= {mb_vo, shift_reg[CSZ-DSZ-1:DSZ]};
          end
          if (last) begin
            state_reg <= RTAIL;
          end
        end
        RTAIL: begin
          state_reg <= IDLE;
          rsp_valid <= 1'b1;
          rsp_data  <= byte_reg ? CSZ'(mb_vo) : {mb_vo, shift_reg};
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb8_cell_rw.sv
// Bench for mb8_cell_rw: behavioural SPRAM, transaction-level schedule model checked every cycle.
module tb_mb8_cell_rw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [16:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        mb_we;
  logic [16:0] mb_ai;
  logic [7:0]  mb_vi;
  logic [7:0]  mb_vo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sp      [0:131071];
  logic [7:0] ref_mem [0:131071];

  // Expected bus activity keyed by absolute cycle number.
  logic [16:0] wr_ai    [int];
  logic [7:0]  wr_vi    [int];
  logic [16:0] rd_ai    [int];
  logic [31:0] rdata_at [int];
  bit          rsp_at   [int];

  logic        exp_we = 1'b0;
  logic        exp_rsp = 1'b0;
  logic [16:0] exp_ai = '0;
  logic [7:0]  exp_vi = '0;
  logic [31:0] exp_rdata = '0;
  int          busy_until = -1;

  mb8_cell_rw dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mb_we     (mb_we),
    .mb_ai     (mb_ai),
    .mb_vi     (mb_vi),
    .mb_vo     (mb_vo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mb_we) sp[mb_ai] <= mb_vi;
    mb_vo <= sp[mb_ai];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : model
    int c;
    int n;
    logic [16:0] a;
    logic [31:0] d;
    logic exp_ready;
    c = cyc;
    if (!rst_n) begin
      wr_ai.delete();
      wr_vi.delete();
      rd_ai.delete();
      rdata_at.delete();
      rsp_at.delete();
      busy_until = -1;
      exp_we = 1'b0;
      exp_ai = '0;
      exp_vi = '0;
      exp_rsp = 1'b0;
      exp_rdata = '0;
    end else begin
      exp_we = 1'b0;
      if (wr_ai.exists(c)) begin
        exp_we = 1'b1;
        exp_ai = wr_ai[c];
        exp_vi = wr_vi[c];
        ref_mem[exp_ai] = exp_vi;
      end else if (rd_ai.exists(c)) begin
        exp_ai = rd_ai[c];
      end
      exp_rsp = rsp_at.exists(c);
      if (rdata_at.exists(c)) exp_rdata = rdata_at[c];
    end
    exp_ready = (c > busy_until);
    chk("mb_we", 32'(mb_we), 32'(exp_we));
    chk("mb_ai", 32'(mb_ai), 32'(exp_ai));
    chk("mb_vi", 32'(mb_vi), 32'(exp_vi));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("rsp_data", rsp_data, exp_rdata);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (rst_n && req_valid && exp_ready) begin
      n = req_byte ? 1 : 4;
      d = '0;
      for (int k = 0; k < n; k++) begin
        a = req_addr + 17'(k);
        if (req_we) begin
          wr_ai[c+1+k] = a;
          wr_vi[c+1+k] = req_wdata[8*k +: 8];
        end else begin
          rd_ai[c+1+k] = a;
          d[8*k +: 8] = ref_mem[a];
        end
      end
      if (req_we) begin
        rsp_at[c+n+1] = 1'b1;
        busy_until = c + n;
      end else begin
        rsp_at[c+n+2] = 1'b1;
        rdata_at[c+n+2] = d;
        busy_until = c + n + 1;
      end
    end
  end

  task automatic issue(input logic we, input logic bo, input logic [16:0] a, input logic [31:0] d,
                       input bit hold, output int t);
    int n;
    n = 0;
    req_we = we;
    req_byte = bo;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept", 32'(req_ready), 32'd1);
    t = cyc;
    @(posedge clk); #2;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int t, output logic [31:0] q, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    q = rsp_data;
    lat = cyc - t;
    @(posedge clk); #2;
  endtask

  task automatic xfer(input string name, input logic we, input logic bo, input logic [16:0] a,
                      input logic [31:0] d, input int exp_lat, output logic [31:0] q);
    int t;
    int lat;
    issue(we, bo, a, d, 1'b0, t);
    wait_rsp(t, q, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    $display("xfer %s we=%0d byte=%0d addr=%h wdata=%h -> rsp %h after %0d cycles", name, we, bo, a, d, q, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int t1;
    int t2;
    int lat;
    int cnt;
    logic [16:0] a;
    for (int i = 0; i < 131072; i++) begin
      sp[i] = 8'($urandom);
      ref_mem[i] = sp[i];
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_mb_ai", 32'(mb_ai), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    xfer("st_cell", 1'b1, 1'b0, 17'h00100, 32'h12345678, 5, q);
    chk("st_mem", {sp[17'h103], sp[17'h102], sp[17'h101], sp[17'h100]}, 32'h12345678);
    xfer("ld_cell", 1'b0, 1'b0, 17'h00100, 32'h0, 6, q);
    chk("ld_cell_data", q, 32'h12345678);
    xfer("st_byte", 1'b1, 1'b1, 17'h00102, 32'hFFFFFFAB, 2, q);
    xfer("ld_cell2", 1'b0, 1'b0, 17'h00100, 32'h0, 6, q);
    chk("ld_cell2_data", q, 32'h12AB5678);
    xfer("ld_byte", 1'b0, 1'b1, 17'h00102, 32'h0, 3, q);
    chk("ld_byte_data", q, 32'h000000AB);

    xfer("st_wrap", 1'b1, 1'b0, 17'h1FFFE, 32'hDEADBEEF, 5, q);
    chk("wrap_mem", {sp[17'h00001], sp[17'h00000], sp[17'h1FFFF], sp[17'h1FFFE]}, 32'hDEADBEEF);
    xfer("ld_wrap", 1'b0, 1'b0, 17'h1FFFE, 32'h0, 6, q);
    chk("ld_wrap_data", q, 32'hDEADBEEF);

    issue(1'b1, 1'b0, 17'h00040, 32'hCAFEF00D, 1'b1, t1);
    issue(1'b0, 1'b0, 17'h00040, 32'h0, 1'b0, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd5);
    wait_rsp(t2, q, lat);
    chk("b2b_lat", 32'(lat), 32'd6);
    chk("b2b_data", q, 32'hCAFEF00D);
    $display("xfer b2b store@40 accepted %0d, load accepted %0d, data %h", t1, t2, q);

    xfer("st_pre", 1'b1, 1'b0, 17'h00200, 32'h11223344, 5, q);
    issue(1'b1, 1'b0, 17'h00200, 32'hA5A5A5A5, 1'b0, t1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mb_we", 32'(mb_we), 32'd0);
    chk("abort_mb_ai", 32'(mb_ai), 32'h0);
    chk("abort_mb_vi", 32'(mb_vi), 32'h0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("abort_mem", {sp[17'h203], sp[17'h202], sp[17'h201], sp[17'h200]}, 32'h1122A5A5);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (rsp_valid) cnt++;
    end
    chk("abort_no_rsp", 32'(cnt), 32'd0);
    xfer("ld_abort", 1'b0, 1'b0, 17'h00200, 32'h0, 6, q);
    chk("ld_abort_data", q, 32'h1122A5A5);

    for (int i = 0; i < 80; i++) begin
      int gap;
      logic we;
      logic bo;
      logic [31:0] d;
      we = 1'($urandom_range(0, 1));
      bo = ($urandom_range(0, 2) == 0);
      d = $urandom;
      a = 17'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = 17'h1FFFC + 17'($urandom_range(0, 3));
      gap = $urandom_range(0, 3);
      issue(we, bo, a, d, gap == 0, t1);
      $display("rand %0d we=%0d byte=%0d addr=%h wdata=%h accepted at %0d", i, we, bo, a, d, t1);
      if (gap != 0) begin
        repeat (gap) begin
          @(posedge clk); #2;
        end
      end
    end
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
